// File: rtl/stripe_scheduler.sv
// Stripe initiator for a PE array: loads PE_NUM-base B stripes, streams A bases, collects stripe scores.
// Optional feature: define GLOBAL_MAX_EN to add o_global_max (running max of reported scores).
module stripe_scheduler #(
    parameter int PE_NUM  = 64,
    parameter int ADDR_W  = 10,
    parameter int LEN_A   = 1024,
    parameter int SCORE_W = 14,
    parameter int STR_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_go,
    input  logic [STR_W-1:0]      i_num_stripes,
    output logic [ADDR_W-1:0]     o_addr_a,
    input  logic [1:0]            i_data_a,
    output logic [ADDR_W-1:0]     o_addr_b,
    input  logic [1:0]            i_data_b,
    output logic [2*PE_NUM-1:0]   o_B,
    output logic [1:0]            o_A,
    output logic                  o_start,
    input  logic                  i_stripe_end,
    input  logic [ADDR_W-1:0]     i_start_position,
    input  logic [SCORE_W-1:0]    i_max_score,
    output logic                  o_score_valid,
    output logic [SCORE_W-1:0]    o_score,
    output logic [STR_W-1:0]      o_stripe_idx,
    output logic                  o_timeout,
    output logic                  o_busy,
    output logic                  o_done
`ifdef GLOBAL_MAX_EN
    ,
    output logic [SCORE_W-1:0]    o_global_max
`endif
);

    localparam int CNT_W = $clog2(PE_NUM + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_B   = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_WAIT_END = 3'd4;
    localparam logic [2:0] S_REPORT   = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_A        = ADDR_W'(LEN_A - 1);
    localparam logic [ADDR_W:0]   LEN_A_X       = (ADDR_W + 1)'(LEN_A);
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(PE_NUM);
    localparam logic [CNT_W-1:0]  CNT_ADDR_LAST = CNT_W'(PE_NUM - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST      = TMR_W'(TIMEOUT - 1);

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [STR_W-1:0]    k_q, k_d;
    logic [STR_W-1:0]    num_q, num_d;
    logic [ADDR_W-1:0]   pos_q, pos_d;
    logic [ADDR_W-1:0]   off_q, off_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic                start_q, start_d;
    logic [1:0]          a_hold_q, a_hold_d;
    logic                timeout_q, timeout_d;
    logic [1:0]          b_q [PE_NUM];

    logic [STR_W:0]      k_inc;
    logic [ADDR_W:0]     pos_sum;

    assign k_inc   = {1'b0, k_q} + (STR_W + 1)'(1);
    assign pos_sum = {1'b0, pos_q} + {1'b0, off_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        k_d       = k_q;
        num_d     = num_q;
        pos_d     = pos_q;
        off_d     = off_q;
        score_d   = score_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        start_d   = start_q;
        timeout_d = timeout_q;
        a_hold_d  = start_q ? i_data_a : a_hold_q;
        case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    timeout_d = 1'b0;
                    k_d       = '0;
                    pos_d     = '0;
                    num_d     = i_num_stripes;
                    if (i_num_stripes == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_LOAD_B;
                        cnt_d    = '0;
                        addr_b_d = '0;
                    end
                end
            end
            S_LOAD_B: begin
                // Address runs one cycle ahead of the lane write, hence PE_NUM+1 cycles.
                if (cnt_q < CNT_ADDR_LAST) addr_b_d = addr_b_q + ADDR_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_SETTLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_SETTLE: begin
                addr_a_d = pos_q;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                if (i_stripe_end) begin
                    score_d = i_max_score;
                    off_d   = i_start_position;
                    start_d = 1'b0;
                    state_d = S_REPORT;
                end else begin
                    start_d = 1'b1;
                    if (addr_a_q == LAST_A) begin
                        state_d = S_WAIT_END;
                        tmr_d   = '0;
                    end else begin
                        addr_a_d = addr_a_q + ADDR_W'(1);
                    end
                end
            end
            S_WAIT_END: begin
                start_d = 1'b0;
                if (i_stripe_end) begin
                    score_d = i_max_score;
                    off_d   = i_start_position;
                    state_d = S_REPORT;
                end else if (!start_q) begin
                    // Timer only runs once the final base has left.
                    if (tmr_q == TMR_LAST) begin
                        score_d   = '0;
                        off_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = S_REPORT;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            S_REPORT: begin
                if (pos_sum >= LEN_A_X) begin
                    state_d = S_DONE;
                end else begin
                    pos_d = pos_sum[ADDR_W-1:0];
                    if (k_inc < {1'b0, num_q}) begin
                        k_d      = k_inc[STR_W-1:0];
                        cnt_d    = '0;
                        addr_b_d = ADDR_W'(32'(k_inc) * PE_NUM);
                        state_d  = S_LOAD_B;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            k_q       <= '0;
            num_q     <= '0;
            pos_q     <= '0;
            off_q     <= '0;
            score_q   <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            start_q   <= 1'b0;
            a_hold_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            k_q       <= k_d;
            num_q     <= num_d;
            pos_q     <= pos_d;
            off_q     <= off_d;
            score_q   <= score_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            start_q   <= start_d;
            a_hold_q  <= a_hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Lane gi receives the data returned for address n=gi, one cycle after it was issued.
    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                b_q[gi] <= '0;
            end else if (state_q == S_LOAD_B && cnt_q == CNT_W'(gi + 1)) begin
                b_q[gi] <= i_data_b;
            end
        end
        assign o_B[2*gi +: 2] = b_q[gi];
    end

`ifdef GLOBAL_MAX_EN
    logic [SCORE_W-1:0] gmax_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gmax_q <= '0;
        end else if (state_q == S_IDLE && i_go) begin
            gmax_q <= '0;
        end else if (state_q == S_REPORT && score_q > gmax_q) begin
            gmax_q <= score_q;
        end
    end

    assign o_global_max = gmax_q;
`else
    // Running maximum not tracked in this build.
`endif

    assign o_addr_a      = addr_a_q;
    assign o_addr_b      = addr_b_q;
    assign o_start       = start_q;
    assign o_A           = start_q ? i_data_a : a_hold_q;
    assign o_score_valid = (state_q == S_REPORT);
    assign o_score       = score_q;
    assign o_stripe_idx  = k_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_stripe_scheduler.sv
// Directed bench for stripe_scheduler: sequence memories, a PE-array model that ends stripes on cue,
// table-driven runs plus hand sequences for empty run, go-while-busy and mid-run reset.
module tb_stripe_scheduler;

    logic          clk;
    logic          i_rst;
    logic          i_go;
    logic [3:0]    i_num_stripes;
    logic [9:0]    o_addr_a;
    logic [1:0]    i_data_a;
    logic [9:0]    o_addr_b;
    logic [1:0]    i_data_b;
    logic [127:0]  o_B;
    logic [1:0]    o_A;
    logic          o_start;
    logic          i_stripe_end;
    logic [9:0]    i_start_position;
    logic [13:0]   i_max_score;
    logic          o_score_valid;
    logic [13:0]   o_score;
    logic [3:0]    o_stripe_idx;
    logic          o_timeout;
    logic          o_busy;
    logic          o_done;
`ifdef GLOBAL_MAX_EN
    logic [13:0]   o_global_max;
`endif

    stripe_scheduler dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_go             (i_go),
        .i_num_stripes    (i_num_stripes),
        .o_addr_a         (o_addr_a),
        .i_data_a         (i_data_a),
        .o_addr_b         (o_addr_b),
        .i_data_b         (i_data_b),
        .o_B              (o_B),
        .o_A              (o_A),
        .o_start          (o_start),
        .i_stripe_end     (i_stripe_end),
        .i_start_position (i_start_position),
        .i_max_score      (i_max_score),
        .o_score_valid    (o_score_valid),
        .o_score          (o_score),
        .o_stripe_idx     (o_stripe_idx),
        .o_timeout        (o_timeout),
        .o_busy           (o_busy),
        .o_done           (o_done)
`ifdef GLOBAL_MAX_EN
        ,
        .o_global_max     (o_global_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read sequence memories
    logic [1:0] mem_a [1024];
    logic [1:0] mem_b [1024];
    always @(posedge clk) begin
        i_data_a <= mem_a[o_addr_a];
        i_data_b <= mem_b[o_addr_b];
    end

    typedef struct {
        int num;
        int end_at [3];
        int score [3];
        int off [3];
        int exp_pulses;
        int exp_timeout;
        int exp_gmax;
    } vec_t;

    vec_t vecs [5];

    int checks = 0;
    int errors = 0;

    // PE-array model configuration and observations
    int cfg_end [3];
    int cfg_score [3];
    int cfg_off [3];
    int m_s;
    int sh_cnt [8];
    int first_addr [8];
    int a_err [8];
    int sv_score [8];
    int sv_idx [8];
    int sv_gap [8];
    logic [127:0] sv_B [8];
    int addr_b_after [8];
    int pulses, done_cnt, pre_cnt, gap_cnt;
    logic [9:0] prev_addr_a;
    bit prev_sv;
    logic to_at_done;
    logic [13:0] gmax_at_done;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_b(input int s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 64; n++) r[2*n +: 2] = mem_b[s*64 + n];
        return r;
    endfunction

    task automatic clear_mon();
        m_s = 0;
        pulses = 0;
        done_cnt = 0;
        pre_cnt = 0;
        gap_cnt = 0;
        prev_sv = 0;
        to_at_done = 1'bx;
        gmax_at_done = 'x;
        for (int i = 0; i < 8; i++) begin
            sh_cnt[i] = 0;
            first_addr[i] = 0;
            a_err[i] = 0;
            sv_score[i] = -1;
            sv_idx[i] = -1;
            sv_gap[i] = -1;
            sv_B[i] = 'x;
            addr_b_after[i] = -1;
        end
    endtask

    // PE-array model: raises i_stripe_end on the cycle carrying base index cfg_end of the stripe
    initial begin
        i_stripe_end = 1'b0;
        i_start_position = '0;
        i_max_score = '0;
        prev_addr_a = '0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (prev_sv && m_s >= 1 && m_s < 8) addr_b_after[m_s-1] = int'(o_addr_b);
            prev_sv = 0;
            i_stripe_end = 1'b0;
            if (o_score_valid) begin
                if (m_s < 8) begin
                    sv_score[m_s] = int'(o_score);
                    sv_idx[m_s] = int'(o_stripe_idx);
                    sv_gap[m_s] = gap_cnt;
                    sv_B[m_s] = o_B;
                end
                pulses++;
                m_s++;
                prev_sv = 1;
                gap_cnt = 0;
            end else if (o_start && m_s < 8) begin
                int idx;
                if (sh_cnt[m_s] == 0) first_addr[m_s] = int'(prev_addr_a);
                idx = first_addr[m_s] + sh_cnt[m_s];
                if (idx >= 1024 || o_A !== mem_a[idx]) a_err[m_s]++;
                gap_cnt = 0;
                if (m_s < 3 && sh_cnt[m_s] == cfg_end[m_s]) begin
                    i_stripe_end = 1'b1;
                    i_max_score = 14'(cfg_score[m_s]);
                    i_start_position = 10'(cfg_off[m_s]);
                end
                sh_cnt[m_s]++;
            end else if (o_busy) begin
                gap_cnt++;
                if (m_s == 0 && sh_cnt[0] == 0) pre_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                to_at_done = o_timeout;
`ifdef GLOBAL_MAX_EN
                gmax_at_done = o_global_max;
`endif
            end
            prev_addr_a = o_addr_a;
        end
    end

    task automatic set_vec(input int i, input int num, input int e0, input int e1, input int e2,
                           input int s0, input int s1, input int s2, input int f0, input int f1,
                           input int f2, input int p, input int t, input int g);
        vecs[i].num = num;
        vecs[i].end_at[0] = e0; vecs[i].end_at[1] = e1; vecs[i].end_at[2] = e2;
        vecs[i].score[0] = s0;  vecs[i].score[1] = s1;  vecs[i].score[2] = s2;
        vecs[i].off[0] = f0;    vecs[i].off[1] = f1;    vecs[i].off[2] = f2;
        vecs[i].exp_pulses = p;
        vecs[i].exp_timeout = t;
        vecs[i].exp_gmax = g;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int pos;
        for (int i = 0; i < 3; i++) begin
            cfg_end[i] = v.end_at[i];
            cfg_score[i] = v.score[i];
            cfg_off[i] = v.off[i];
        end
        @(negedge clk);
        clear_mon();
        i_num_stripes = 4'(v.num);
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        i_num_stripes = '0;
        // A second go while busy, asking for more stripes, must be ignored
        repeat (18) @(negedge clk);
        i_go = 1'b1;
        i_num_stripes = 4'd9;
        @(negedge clk);
        i_go = 1'b0;
        i_num_stripes = '0;
        n = 0;
        while (!o_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, o_done, 1'b1);
        @(negedge clk);
        chk({tag, "_busy_low"}, o_busy, 1'b0);
        chk({tag, "_pulses"}, pulses, v.exp_pulses);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_timeout"}, to_at_done, v.exp_timeout[0]);
        chk({tag, "_pre_cycles"}, pre_cnt, 67);
`ifdef GLOBAL_MAX_EN
        chk({tag, "_gmax"}, gmax_at_done, v.exp_gmax[13:0]);
`endif
        pos = 0;
        for (int s = 0; s < v.exp_pulses && s < 3; s++) begin
            int avail;
            bit to;
            avail = 1024 - pos;
            to = (v.end_at[s] >= avail);
            chk($sformatf("%s_s%0d_first_addr", tag, s), first_addr[s], pos);
            chk($sformatf("%s_s%0d_start_cycles", tag, s), sh_cnt[s], to ? avail : v.end_at[s] + 1);
            chk($sformatf("%s_s%0d_a_errors", tag, s), a_err[s], 0);
            chk($sformatf("%s_s%0d_score", tag, s), sv_score[s], to ? 0 : v.score[s]);
            chk($sformatf("%s_s%0d_idx", tag, s), sv_idx[s], s);
            chk($sformatf("%s_s%0d_gap", tag, s), sv_gap[s], to ? 255 : 0);
            chk($sformatf("%s_s%0d_B", tag, s), sv_B[s], exp_b(s));
            if (s > 0) chk($sformatf("%s_s%0d_addr_b_first", tag, s), addr_b_after[s-1], s*64);
            if (!to) pos = pos + v.off[s];
        end
        $display("run %s: num %0d pulses %0d timeout %0b", tag, v.num, pulses, to_at_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 2'(i * 7 + (i >> 3));
            mem_b[i] = 2'(i ^ (i >> 2));
        end
        //        num end0 end1 end2  sc0 sc1 sc2  off0 off1 off2  pulses to gmax
        set_vec(0, 1,   70,   0,   0,  37,  0,  0,    5,   0,   0,  1,     0, 37);
        set_vec(1, 2,   70,  20,   0, 120, 95,  0,  100,   3,   0,  2,     0, 120);
        set_vec(2, 1, 5000,   0,   0,  77,  0,  0,    9,   0,   0,  1,     1, 0);
        set_vec(3, 5,    5,   5,   5,  11, 22, 33, 1000,  30,   1,  2,     0, 22);
        set_vec(4, 3,   10,  10,  10,  37,120, 95,   10,  10,  10,  3,     0, 120);

        i_rst = 1'b1;
        i_go = 1'b0;
        i_num_stripes = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_addr_a, o_addr_b, o_B, o_A, o_start, o_score_valid, o_score,
                              o_stripe_idx, o_timeout, o_busy, o_done}, '0);
        i_rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Zero stripes: straight to DONE on the next cycle
        @(negedge clk);
        clear_mon();
        i_num_stripes = 4'd0;
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        chk("num0_busy_done", {o_busy, o_done}, 2'b11);
        @(negedge clk);
        chk("num0_idle", {o_busy, o_done}, 2'b00);
        chk("num0_no_score", pulses, 0);
        $display("run num0: busy/done sequence observed");

        // Reset in the middle of streaming
        for (int i = 0; i < 3; i++) cfg_end[i] = 5000;
        @(negedge clk);
        clear_mon();
        i_num_stripes = 4'd2;
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        n = 0;
        while (sh_cnt[0] < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_stream", sh_cnt[0] >= 10, 1'b1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_outputs", {o_addr_a, o_addr_b, o_B, o_A, o_start, o_score_valid, o_score,
                               o_stripe_idx, o_timeout, o_busy, o_done}, '0);
        @(negedge clk);
        i_rst = 1'b0;
        chk("midrst_no_pulses", pulses + done_cnt, 0);
        $display("run midrst: reset after %0d streamed bases", sh_cnt[0]);

        run_vec(vecs[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
